// File: rtl/ft_pkg.sv
// Shared types and defaults for the fault-tolerance replay path.
package ft_pkg;
    localparam int REPLAY_ADDR_W   = 5;
    localparam int REPLAY_DATA_W   = 32;
    localparam int REPLAY_NUM_REGS = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HALT,
        ST_REPLAY,
        ST_WAIT_RESUME,
        ST_PC_LOAD,
        ST_RELEASE
    } rf_replay_state_e;
endpackage

// File: rtl/replay_beat_checker.sv
// Expected-address tracking and registered RF write stage for replay beats.
module replay_beat_checker
    import ft_pkg::*;
#(
    parameter int ADDR_WIDTH = REPLAY_ADDR_W,
    parameter int DATA_WIDTH = REPLAY_DATA_W,
    parameter int NUM_REGS   = REPLAY_NUM_REGS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  beat,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  mismatch,
    output logic                  last,
    output logic                  rf_we,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata
);
    localparam int CNT_W = $clog2(NUM_REGS + 1);
    localparam int CMP_W = (CNT_W > ADDR_WIDTH) ? CNT_W : ADDR_WIDTH;

    logic [CNT_W-1:0] cnt;
    logic             match;

    assign match    = (CMP_W'(addr) == CMP_W'(cnt));
    assign mismatch = beat && !match;
    assign last     = beat && (cnt == CNT_W'(NUM_REGS - 1));

    // A mismatched beat still advances the counter so one bad beat stays isolated.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= beat && match && (addr != '0);
            if (clear)
                cnt <= '0;
            else if (beat && (cnt != CNT_W'(NUM_REGS)))
                cnt <= cnt + CNT_W'(1);
            if (beat) begin
                rf_waddr <= addr;
                rf_wdata <= data;
            end
        end
    end
endmodule

// File: rtl/rf_replay_sink.sv
// Core-side replay sink: freezes fetch, rewrites the RF from the shadow stream,
// reloads the safe PC and releases fetch.
module rf_replay_sink
    import ft_pkg::*;
#(
    parameter int ADDR_WIDTH = REPLAY_ADDR_W,
    parameter int DATA_WIDTH = REPLAY_DATA_W,
    parameter int NUM_REGS   = REPLAY_NUM_REGS
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  halt_i,
    input  logic                  shift_i,
    input  logic                  resume_i,
    input  logic [ADDR_WIDTH-1:0] replay_addr_i,
    input  logic [DATA_WIDTH-1:0] replay_data_i,
    input  logic [DATA_WIDTH-1:0] spc_i,
    output logic                  fetch_en_o,
    output logic                  rf_we_o,
    output logic [ADDR_WIDTH-1:0] rf_waddr_o,
    output logic [DATA_WIDTH-1:0] rf_wdata_o,
    output logic                  pc_set_o,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  seq_err_o
);
    rf_replay_state_e state;
    logic             beat, clear, mismatch, last;

    assign beat  = shift_i && ((state == ST_HALT) || (state == ST_REPLAY));
    assign clear = (state == ST_IDLE) && halt_i;

    replay_beat_checker #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .NUM_REGS  (NUM_REGS)
    ) u_checker (
        .clk     (clk_i),
        .rst     (rst_i),
        .clear   (clear),
        .beat    (beat),
        .addr    (replay_addr_i),
        .data    (replay_data_i),
        .mismatch(mismatch),
        .last    (last),
        .rf_we   (rf_we_o),
        .rf_waddr(rf_waddr_o),
        .rf_wdata(rf_wdata_o)
    );

    // pc_set_o rises one cycle after PC_LOAD is entered so a final-beat write
    // drains before the PC strobe.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            fetch_en_o <= 1'b1;
            pc_set_o   <= 1'b0;
            pc_o       <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            seq_err_o  <= 1'b0;
        end else begin
            pc_set_o <= 1'b0;
            done_o   <= 1'b0;
            case (state)
                ST_IDLE: if (halt_i) begin
                    pc_o       <= spc_i;
                    seq_err_o  <= 1'b0;
                    fetch_en_o <= 1'b0;
                    busy_o     <= 1'b1;
                    state      <= ST_HALT;
                end
                ST_HALT, ST_REPLAY: begin
                    if (mismatch) seq_err_o <= 1'b1;
                    if (resume_i) begin
                        if (!last) seq_err_o <= 1'b1;
                        state <= ST_PC_LOAD;
                    end else if (last) begin
                        state <= ST_WAIT_RESUME;
                    end else if (shift_i) begin
                        state <= ST_REPLAY;
                    end
                end
                ST_WAIT_RESUME: begin
                    if (shift_i)  seq_err_o <= 1'b1;
                    if (resume_i) state <= ST_PC_LOAD;
                end
                ST_PC_LOAD: begin
                    pc_set_o <= 1'b1;
                    state    <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    done_o     <= 1'b1;
                    fetch_en_o <= 1'b1;
                    busy_o     <= 1'b0;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rf_replay_sink.sv
// Directed bench for rf_replay_sink: nominal, mismatch, early resume, extra beat,
// mid-recovery reset and simultaneous final beat with resume.
module tb_rf_replay_sink;
    logic        clk = 1'b0, rst = 1'b1, halt = 1'b0, shift = 1'b0, resume = 1'b0;
    logic [4:0]  raddr = '0;
    logic [31:0] rdata = '0, spc = '0;
    logic        fetch_en, rf_we, pc_set, busy, done, seq_err;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, pc;
    int          total = 0, passed = 0;

    rf_replay_sink dut (
        .clk_i(clk), .rst_i(rst), .halt_i(halt), .shift_i(shift), .resume_i(resume),
        .replay_addr_i(raddr), .replay_data_i(rdata), .spc_i(spc),
        .fetch_en_o(fetch_en), .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
        .pc_set_o(pc_set), .pc_o(pc), .busy_o(busy), .done_o(done), .seq_err_o(seq_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic r, input logic [4:0] a, input logic [31:0] d);
        shift = s; resume = r; raddr = a; rdata = d;
    endtask

    task automatic start(input logic [31:0] pc_val);
        spc = pc_val; halt = 1'b1;
        tick();
        halt = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        total++; if (fetch_en !== 1'b1) $display("FAIL reset_fetch_en got %0b want 1", fetch_en); else passed++;
        total++; if (rf_we !== 1'b0) $display("FAIL reset_rf_we got %0b want 0", rf_we); else passed++;
        total++; if ({pc_set, busy, done, seq_err} !== 4'b0) $display("FAIL reset_flags got %b want 0000", {pc_set, busy, done, seq_err}); else passed++;
        total++; if ({rf_waddr, rf_wdata, pc} !== '0) $display("FAIL reset_data got %0h/%0h/%0h want 0", rf_waddr, rf_wdata, pc); else passed++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_nominal();
        int nwr = 0;
        start(32'h0000_1040);
        total++; if ({fetch_en, busy} !== 2'b01) $display("FAIL nom_halt fetch/busy got %b want 01", {fetch_en, busy}); else passed++;
        for (int a = 0; a < 32; a++) begin
            drive(1'b1, 1'b0, 5'(a), 32'hA000_0000 + 32'(a));
            tick();
            if (rf_we) nwr++;
            total++; if (rf_we !== (a != 0)) $display("FAIL nom_we[%0d] got %0b want %0b", a, rf_we, (a != 0)); else passed++;
            if (a != 0) begin
                total++; if ({rf_waddr, rf_wdata} !== {5'(a), 32'hA000_0000 + 32'(a)})
                    $display("FAIL nom_wr[%0d] got %0h/%0h want %0h/%0h", a, rf_waddr, rf_wdata, a, 32'hA000_0000 + 32'(a)); else passed++;
            end
            total++; if (fetch_en !== 1'b0) $display("FAIL nom_fetch[%0d] got %0b want 0", a, fetch_en); else passed++;
        end
        drive(1'b0, 1'b1, 5'd0, 32'd0);
        tick();
        total++; if ({rf_we, pc_set} !== 2'b00) $display("FAIL nom_resume we/pcset got %b want 00", {rf_we, pc_set}); else passed++;
        drive(1'b0, 1'b0, 5'd0, 32'd0);
        tick();
        total++; if ({pc_set, fetch_en} !== 2'b10) $display("FAIL nom_pcset pcset/fetch got %b want 10", {pc_set, fetch_en}); else passed++;
        total++; if (pc !== 32'h0000_1040) $display("FAIL nom_pc got %0h want 1040", pc); else passed++;
        tick();
        total++; if ({done, fetch_en, busy, pc_set, seq_err} !== 5'b11000) $display("FAIL nom_release got %b want 11000", {done, fetch_en, busy, pc_set, seq_err}); else passed++;
        tick();
        total++; if (done !== 1'b0) $display("FAIL nom_done_pulse got %0b want 0", done); else passed++;
        total++; if (nwr != 31) $display("FAIL nom_write_count got %0d want 31", nwr); else passed++;
    endtask

    task automatic test_mismatch();
        start(32'h0000_1100);
        for (int a = 0; a < 32; a++) begin
            drive(1'b1, 1'b0, (a == 5) ? 5'd7 : 5'(a), 32'hB000_0000 + 32'(a));
            tick();
            if (a == 5) begin
                total++; if ({rf_we, seq_err} !== 2'b01) $display("FAIL mm_slot we/err got %b want 01", {rf_we, seq_err}); else passed++;
            end else if (a > 5) begin
                total++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'(a), 32'hB000_0000 + 32'(a)})
                    $display("FAIL mm_wr[%0d] got %0b/%0h/%0h want 1/%0h/%0h", a, rf_we, rf_waddr, rf_wdata, a, 32'hB000_0000 + 32'(a)); else passed++;
            end
        end
        drive(1'b0, 1'b1, 5'd0, 32'd0);
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'd0);
        tick();
        tick();
        total++; if ({done, seq_err} !== 2'b11) $display("FAIL mm_release done/err got %b want 11", {done, seq_err}); else passed++;
        tick();
    endtask

    task automatic test_early_resume();
        int nwr = 0;
        start(32'h0000_1200);
        total++; if (seq_err !== 1'b0) $display("FAIL er_err_cleared got %0b want 0", seq_err); else passed++;
        for (int a = 0; a < 10; a++) begin
            drive(1'b1, 1'b0, 5'(a), 32'hC000_0000 + 32'(a));
            tick();
            if (rf_we) nwr++;
        end
        total++; if (nwr != 9 || rf_waddr !== 5'd9) $display("FAIL er_writes got %0d last %0d want 9 last 9", nwr, rf_waddr); else passed++;
        drive(1'b0, 1'b1, 5'd0, 32'd0);
        tick();
        total++; if ({seq_err, rf_we, pc_set} !== 3'b100) $display("FAIL er_resume err/we/pcset got %b want 100", {seq_err, rf_we, pc_set}); else passed++;
        drive(1'b0, 1'b0, 5'd0, 32'd0);
        tick();
        total++; if ({pc_set, pc} !== {1'b1, 32'h0000_1200}) $display("FAIL er_pcload got %0b/%0h want 1/1200", pc_set, pc); else passed++;
        tick();
        total++; if (done !== 1'b1) $display("FAIL er_done got %0b want 1", done); else passed++;
        tick();
    endtask

    task automatic test_extra_beat();
        start(32'h0000_1300);
        for (int a = 0; a < 32; a++) begin
            drive(1'b1, 1'b0, 5'(a), 32'hD000_0000 + 32'(a));
            tick();
        end
        total++; if (seq_err !== 1'b0) $display("FAIL xb_before got %0b want 0", seq_err); else passed++;
        drive(1'b1, 1'b0, 5'd5, 32'hDEAD_BEEF);
        tick();
        total++; if ({rf_we, seq_err} !== 2'b01) $display("FAIL xb_extra we/err got %b want 01", {rf_we, seq_err}); else passed++;
        drive(1'b0, 1'b1, 5'd0, 32'd0);
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'd0);
        tick();
        total++; if (pc_set !== 1'b1) $display("FAIL xb_pcset got %0b want 1", pc_set); else passed++;
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        start(32'h0000_1400);
        for (int a = 0; a <= 12; a++) begin
            drive(1'b1, 1'b0, (a == 3) ? 5'd9 : 5'(a), 32'hE000_0000 + 32'(a));
            tick();
        end
        total++; if ({rf_we, rf_waddr, seq_err} !== {1'b1, 5'd12, 1'b1}) $display("FAIL rm_pre got %0b/%0d/%0b want 1/12/1", rf_we, rf_waddr, seq_err); else passed++;
        drive(1'b0, 1'b0, 5'd0, 32'd0);
        #2 rst = 1'b1;
        #1;
        total++; if ({fetch_en, busy, rf_we, seq_err, pc_set, done} !== 6'b100000) $display("FAIL rm_async got %b want 100000", {fetch_en, busy, rf_we, seq_err, pc_set, done}); else passed++;
        total++; if ({rf_waddr, rf_wdata, pc} !== '0) $display("FAIL rm_async_data got %0h/%0h/%0h want 0", rf_waddr, rf_wdata, pc); else passed++;
        @(negedge clk);
        rst = 1'b0;
        start(32'h0000_1500);
        total++; if ({seq_err, busy, fetch_en, pc} !== {3'b010, 32'h0000_1500}) $display("FAIL rm_restart got %b/%0h want 010/1500", {seq_err, busy, fetch_en}, pc); else passed++;
        drive(1'b1, 1'b0, 5'd0, 32'hF000_0000);
        tick();
        total++; if (rf_we !== 1'b0) $display("FAIL rm_x0 got %0b want 0", rf_we); else passed++;
        drive(1'b1, 1'b0, 5'd1, 32'hF000_0001);
        tick();
        total++; if ({rf_we, rf_waddr, seq_err} !== {1'b1, 5'd1, 1'b0}) $display("FAIL rm_beat1 got %0b/%0d/%0b want 1/1/0", rf_we, rf_waddr, seq_err); else passed++;
        drive(1'b0, 1'b0, 5'd0, 32'd0);
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_final_beat_resume();
        start(32'h0000_1600);
        for (int a = 0; a < 31; a++) begin
            drive(1'b1, 1'b0, 5'(a), 32'h1234_0000 + 32'(a));
            tick();
        end
        drive(1'b1, 1'b1, 5'd31, 32'h1234_001F);
        tick();
        total++; if ({rf_we, rf_waddr, rf_wdata, pc_set} !== {1'b1, 5'd31, 32'h1234_001F, 1'b0})
            $display("FAIL fb_write got %0b/%0d/%0h/%0b want 1/31/1234001f/0", rf_we, rf_waddr, rf_wdata, pc_set); else passed++;
        drive(1'b0, 1'b0, 5'd0, 32'd0);
        tick();
        total++; if ({pc_set, rf_we, seq_err} !== 3'b100) $display("FAIL fb_pcset got %b want 100", {pc_set, rf_we, seq_err}); else passed++;
        total++; if (pc !== 32'h0000_1600) $display("FAIL fb_pc got %0h want 1600", pc); else passed++;
        tick();
        total++; if ({done, fetch_en, seq_err} !== 3'b110) $display("FAIL fb_release got %b want 110", {done, fetch_en, seq_err}); else passed++;
        tick();
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_mismatch();
        test_early_resume();
        test_extra_beat();
        test_reset_mid();
        test_final_beat_resume();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/rf_replay_sink.md
Name: rf_replay_sink

Overview:
- Core-side receiver of the fault-tolerance replay sequence. The error controller halts, shifts and resumes; the shadow register file replays one register per shift cycle.
- This block consumes that stream. It freezes the core front end and rewrites the core's register file with the shadowed values.
- It reloads the program counter from the captured safe PC, then releases fetch. It sits between the fault-tolerance module outputs and the core's RF write port and fetch control.

Parameters:
- ADDR_WIDTH, 5, register address width.
- DATA_WIDTH, 32, register and PC data width.
- NUM_REGS, 32, registers replayed per recovery; must be at most 2**ADDR_WIDTH.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- halt_i  in  1  recovery start request from the error controller (level).
- shift_i  in  1  replay beat valid; one register per cycle it is high.
- resume_i  in  1  replay finished; release request.
- replay_addr_i  in  ADDR_WIDTH  address of the current replay beat.
- replay_data_i  in  DATA_WIDTH  shadow register data for replay_addr_i, same cycle.
- spc_i  in  DATA_WIDTH  safe program counter.
- fetch_en_o  out  1  core fetch enable.
- rf_we_o  out  1  core RF write enable.
- rf_waddr_o  out  ADDR_WIDTH  core RF write address.
- rf_wdata_o  out  DATA_WIDTH  core RF write data.
- pc_set_o  out  1  one-cycle PC load strobe.
- pc_o  out  DATA_WIDTH  PC value to load.
- busy_o  out  1  recovery in progress.
- done_o  out  1  one-cycle pulse at release.
- seq_err_o  out  1  sticky replay-protocol error.

Behaviour:
Reset values (asynchronous, rst_i high at any time, including mid-recovery):
- State goes to IDLE; fetch_en_o=1.
- rf_we_o, pc_set_o, busy_o, done_o and seq_err_o are 0.
- rf_waddr_o, rf_wdata_o and pc_o are 0; the beat counter is 0.

State machine (registered state): IDLE, HALT, REPLAY, WAIT_RESUME, PC_LOAD, RELEASE.

IDLE:
- fetch_en_o=1, busy_o=0.
- When halt_i=1: capture spc_i into the pc register, clear the beat counter, clear seq_err_o, go to HALT.
- shift_i and resume_i are ignored.

HALT:
- fetch_en_o=0, busy_o=1.
- shift_i=1: process the beat (below) and go to REPLAY.
- resume_i=1 with no beat: set seq_err_o, go to PC_LOAD.

REPLAY:
- fetch_en_o=0, busy_o=1.
- Each cycle with shift_i=1 is one beat.
- When the beat counter reaches NUM_REGS, go to WAIT_RESUME.
- resume_i=1 before the count is reached: set seq_err_o, go to PC_LOAD.

WAIT_RESUME:
- resume_i=1: go to PC_LOAD.
- shift_i=1 (extra beat): set seq_err_o, beat ignored, no write.

PC_LOAD (one cycle): pc_set_o=1, pc_o holds the captured spc; go to RELEASE.

RELEASE (one cycle): done_o=1, fetch_en_o=1, busy_o=0; go to IDLE.

Beat processing:
- The expected address equals the beat counter value.
- Write outputs are registered with one-cycle latency: a beat in cycle N gives rf_we_o/rf_waddr_o/rf_wdata_o in cycle N+1.
- rf_we_o=1 only if replay_addr_i equals the expected address and replay_addr_i is not 0; x0 is never written.
- On address mismatch: seq_err_o is set and the write is suppressed. The counter still increments, so one skipped beat does not cascade.
- Counter width is clog2(NUM_REGS+1); it saturates at NUM_REGS.

Other boundary rules:
- halt_i in any non-IDLE state is ignored; re-triggering requires a return to IDLE.
- shift_i and resume_i high in the same cycle in REPLAY: the beat is processed first, then the resume rule applies. The last beat with resume counts as complete.
- A write issued in the final beat cycle drains during the next state; pc_set_o is never asserted in the same cycle as rf_we_o.
- seq_err_o stays high until the next recovery start or reset.

Decomposition:
- Shared package ft_pkg holds:
  - state enum rf_replay_state_e;
  - REPLAY_ADDR_W and REPLAY_DATA_W constants;
  - default NUM_REGS.
- One natural sub-module: replay_beat_checker. It contains the expected-address counter, the address comparison, x0 masking and the registered write stage. The top level holds the FSM and the PC capture.

Test Plan:
- Nominal recovery: spc_i=0x0000_1040, pulse halt_i, 32 beats with addr 0..31 and data 0xA000_0000+addr, then resume_i. Required: 31 writes (addr 1..31, data matching, addr 0 not written); pc_set_o pulse with pc_o=0x0000_1040; done_o pulse; seq_err_o=0; fetch_en_o low from halt+1 until RELEASE.
- Address mismatch: beat 5 carries addr 7. Required: no write in that slot, seq_err_o=1 from the next cycle, beats 6..31 still written correctly.
- Early resume: resume_i after 10 beats. Required: seq_err_o=1, PC_LOAD on the next cycle, only addr 1..9 written.
- Extra beat: a 33rd shift_i in WAIT_RESUME. Required: no rf_we_o, seq_err_o=1.
- Reset mid-recovery: assert rst_i after beat 12. Required: outputs return to reset values asynchronously (fetch_en_o=1 in the same cycle). A subsequent halt restarts cleanly with seq_err_o=0.
- Simultaneous final beat and resume: beat 31 with resume_i=1. Required: addr 31 written, seq_err_o=0, pc_set_o one cycle after the write.
